// File: rtl/ysyx_24110006_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter. Names keep the arbiter's i_/o_ view.
// master: the arbiter itself. slave: the IFU, LSU and memory agents around it.
interface ysyx_24110006_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int MASK_W = DATA_W / 8;

   logic              i_m0_valid, o_m0_ready, i_m0_wen, o_m0_rvalid, o_m0_err;
   logic [ADDR_W-1:0] i_m0_addr;
   logic [DATA_W-1:0] i_m0_wdata, o_m0_rdata;
   logic [MASK_W-1:0] i_m0_wmask;

   logic              i_m1_valid, o_m1_ready, i_m1_wen, o_m1_rvalid, o_m1_err;
   logic [ADDR_W-1:0] i_m1_addr;
   logic [DATA_W-1:0] i_m1_wdata, o_m1_rdata;
   logic [MASK_W-1:0] i_m1_wmask;

   logic              o_s_valid, i_s_ready, o_s_wen, i_s_rvalid, i_s_err, o_busy;
   logic [ADDR_W-1:0] o_s_addr;
   logic [DATA_W-1:0] o_s_wdata, i_s_rdata;
   logic [MASK_W-1:0] o_s_wmask;

   modport master (
      input  i_m0_valid, i_m0_addr, i_m0_wen, i_m0_wdata, i_m0_wmask,
      output o_m0_ready, o_m0_rvalid, o_m0_rdata, o_m0_err,
      input  i_m1_valid, i_m1_addr, i_m1_wen, i_m1_wdata, i_m1_wmask,
      output o_m1_ready, o_m1_rvalid, o_m1_rdata, o_m1_err,
      output o_s_valid, o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_busy,
      input  i_s_ready, i_s_rvalid, i_s_rdata, i_s_err
   );

   modport slave (
      output i_m0_valid, i_m0_addr, i_m0_wen, i_m0_wdata, i_m0_wmask,
      input  o_m0_ready, o_m0_rvalid, o_m0_rdata, o_m0_err,
      output i_m1_valid, i_m1_addr, i_m1_wen, i_m1_wdata, i_m1_wmask,
      input  o_m1_ready, o_m1_rvalid, o_m1_rdata, o_m1_err,
      input  o_s_valid, o_s_addr, o_s_wen, o_s_wdata, o_s_wmask, o_busy,
      output i_s_ready, i_s_rvalid, i_s_rdata, i_s_err
   );
endinterface

// File: rtl/ysyx_24110006_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (m0) and LSU (m1),
// one transaction in flight, with a watchdog that turns a hung slave into an error.
module ysyx_24110006_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                               i_clock,
   input  logic                               i_reset_n,
   ysyx_24110006_mem_arbiter_if.master        bus
);
   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                   state;
   logic                     last_grant, grant;
   logic [ADDR_W-1:0]        addr_q;
   logic                     wen_q;
   logic [DATA_W-1:0]        wdata_q;
   logic [MASK_W-1:0]        wmask_q;
   logic [1:0]               rvalid_q, err_q;
   logic [1:0][DATA_W-1:0]   rdata_q;
   logic [CNT_W-1:0]         wd_cnt;

   logic                     req_any, winner, grant_ok, wd_fire;

   always_comb begin
      req_any  = bus.i_m0_valid | bus.i_m1_valid;
      // With both requesting, the master that did not win last time goes next.
      winner   = (bus.i_m0_valid & bus.i_m1_valid) ? ~last_grant : bus.i_m1_valid;
      grant_ok = (state == IDLE) & req_any & i_reset_n;
      wd_fire  = (TIMEOUT != 0) && (wd_cnt >= WD_MAX) &&
                 (((state == ADDR) && !bus.i_s_ready) ||
                  ((state == DATA) && !bus.i_s_rvalid));
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
         err_q      <= '0;
         wd_cnt     <= '0;
      end else begin
         rvalid_q <= '0;
         unique case (state)
            IDLE: begin
               if (req_any) begin
                  grant      <= winner;
                  last_grant <= winner;
                  addr_q     <= winner ? bus.i_m1_addr  : bus.i_m0_addr;
                  wen_q      <= winner ? bus.i_m1_wen   : bus.i_m0_wen;
                  wdata_q    <= winner ? bus.i_m1_wdata : bus.i_m0_wdata;
                  wmask_q    <= winner ? bus.i_m1_wmask : bus.i_m0_wmask;
                  wd_cnt     <= CNT_W'(1);
                  state      <= ADDR;
               end
            end
            ADDR, DATA: begin
               if (wd_fire) begin
                  rvalid_q[grant] <= 1'b1;
                  rdata_q[grant]  <= '0;
                  err_q[grant]    <= 1'b1;
                  state           <= IDLE;
               end else if (state == ADDR) begin
                  if (bus.i_s_ready) state <= DATA;
               end else if (bus.i_s_rvalid) begin
                  rvalid_q[grant] <= 1'b1;
                  rdata_q[grant]  <= bus.i_s_rdata;
                  err_q[grant]    <= bus.i_s_err;
                  state           <= IDLE;
               end
               // Saturate so a late handshake past TIMEOUT still trips the watchdog.
               if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_m0_ready  = grant_ok & ~winner;
   assign bus.o_m1_ready  = grant_ok &  winner;
   assign bus.o_m0_rvalid = rvalid_q[0];
   assign bus.o_m1_rvalid = rvalid_q[1];
   assign bus.o_m0_rdata  = rdata_q[0];
   assign bus.o_m1_rdata  = rdata_q[1];
   assign bus.o_m0_err    = err_q[0];
   assign bus.o_m1_err    = err_q[1];
   assign bus.o_s_valid   = (state == ADDR);
   assign bus.o_s_addr    = addr_q;
   assign bus.o_s_wen     = wen_q;
   assign bus.o_s_wdata   = wdata_q;
   assign bus.o_s_wmask   = wmask_q;
   assign bus.o_busy      = (state != IDLE);
endmodule
